// File: rtl/stream_arb_mux.sv
// N-to-1 stream arbiter/mux: fixed-priority or round-robin selection of valid channels
// into a single registered output stage with valid/ready handshaking.
module stream_arb_mux #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned RR_MODE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [NUM_IN-1:0]       ch_enable,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_IN)-1:0] out_sel,
    input  logic                    out_ready
);

    localparam int unsigned SELW = $clog2(NUM_IN);

    logic [SELW-1:0]   r_ptr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SELW-1:0]   r_out_sel;

    logic [NUM_IN-1:0] w_req;
    logic [SELW-1:0]   w_base;
    logic [SELW-1:0]   w_j;
    logic [SELW-1:0]   w_idx;
    logic              w_found;
    logic              w_load;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_ch [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign w_ch[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign w_req  = in_valid & ch_enable;
    assign w_base = (RR_MODE != 0) ? r_ptr : '0;
    assign w_load = ~r_out_valid | out_ready;

    // Scan from w_base with modulo-NUM_IN wrap; first requesting channel wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            w_j = SELW'((32'(w_base) + k) % NUM_IN);
            if (!w_found && w_req[w_j]) begin
                w_found = 1'b1;
                w_idx   = w_j;
            end
        end
    end

    assign w_xfer   = w_load & w_found & ~reset;
    assign in_ready = w_xfer ? (NUM_IN'(1) << w_idx) : '0;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ch[w_idx];
            r_out_sel   <= w_idx;
            r_ptr       <= SELW'((32'(w_idx) + 32'd1) % NUM_IN);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: directed vector table, hand sequences and random stimulus
// checked against an integer-level arbitration model (RR 4ch, fixed 4ch, RR 3ch).
module tb_stream_arb_mux;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned N3 = 3;
    localparam int unsigned W3 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset = 1'b1;
    logic [N-1:0]        in_valid = '0, ch_enable = '0;
    logic [N*W-1:0]      in_data = '0;
    logic                out_ready = 1'b0;
    logic [N-1:0]        rdy_rr, rdy_fp;
    logic                ov_rr, ov_fp;
    logic [W-1:0]        od_rr, od_fp;
    logic [1:0]          os_rr, os_fp;

    logic [N3-1:0]       v3 = '0, e3 = '0, rdy3;
    logic [N3*W3-1:0]    d3 = '0;
    logic                ordy3 = 1'b0, ov3;
    logic [W3-1:0]       od3;
    logic [1:0]          os3;

    stream_arb_mux #(.WIDTH(W), .NUM_IN(N), .RR_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_rr),
        .ch_enable(ch_enable), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
        .out_ready(out_ready));

    stream_arb_mux #(.WIDTH(W), .NUM_IN(N), .RR_MODE(0)) u_fp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_fp),
        .ch_enable(ch_enable), .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp),
        .out_ready(out_ready));

    stream_arb_mux #(.WIDTH(W3), .NUM_IN(N3), .RR_MODE(1)) u_rr3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .ch_enable(e3), .out_valid(ov3), .out_data(od3), .out_sel(os3),
        .out_ready(ordy3));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state per instance: 0 = u_rr, 1 = u_fp, 2 = u_rr3.
    int          m_ptr  [3] = '{0, 0, 0};
    bit          m_ov   [3] = '{0, 0, 0};
    logic [31:0] m_data [3] = '{0, 0, 0};
    int          m_sel  [3] = '{0, 0, 0};

    logic [N-1:0] s_rdy_rr, s_rdy_fp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int grant_of(input int d, input int n, input bit rr,
                                    input logic [15:0] req, input bit ordy);
        int base;
        if (reset) return -1;
        if (m_ov[d] && !ordy) return -1;
        base = rr ? m_ptr[d] : 0;
        for (int k = 0; k < n; k++) begin
            if (req[(base + k) % n]) return (base + k) % n;
        end
        return -1;
    endfunction

    task automatic model_upd(input int d, input int n, input int g, input bit ordy,
                             input logic [31:0] word);
        if (reset) begin
            m_ov[d] = 0; m_data[d] = '0; m_sel[d] = 0; m_ptr[d] = 0;
        end else if (g >= 0) begin
            m_ov[d] = 1; m_data[d] = word; m_sel[d] = g; m_ptr[d] = (g + 1) % n;
        end else if (ordy) begin
            m_ov[d] = 0;
        end
    endtask

    function automatic logic [31:0] onehot(input int g);
        return (g < 0) ? 32'd0 : (32'd1 << g);
    endfunction

    // One clock: drive at negedge, check in_ready before the edge, outputs after it.
    task automatic cycle(input logic rst, input logic [3:0] v, input logic [3:0] en,
                         input logic ordy, input logic [127:0] data);
        int g0, g1, g2;
        @(negedge clk);
        reset = rst; in_valid = v; ch_enable = en; out_ready = ordy; in_data = data;
        v3    = 3'($urandom);
        e3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
        ordy3 = ($urandom_range(0, 3) != 0);
        d3    = 24'($urandom);
        #1;
        g0 = grant_of(0, 4, 1'b1, 16'(v & en), ordy);
        g1 = grant_of(1, 4, 1'b0, 16'(v & en), ordy);
        g2 = grant_of(2, 3, 1'b1, 16'(v3 & e3), ordy3);
        s_rdy_rr = rdy_rr;
        s_rdy_fp = rdy_fp;
        chk("rr_in_ready", 32'(rdy_rr), onehot(g0));
        chk("fp_in_ready", 32'(rdy_fp), onehot(g1));
        chk("rr3_in_ready", 32'(rdy3), onehot(g2));
        model_upd(0, 4, g0, ordy, (g0 >= 0) ? data[g0*32 +: 32] : 32'd0);
        model_upd(1, 4, g1, ordy, (g1 >= 0) ? data[g1*32 +: 32] : 32'd0);
        model_upd(2, 3, g2, ordy3, (g2 >= 0) ? 32'(d3[g2*8 +: 8]) : 32'd0);
        @(posedge clk);
        #1;
        chk("rr_out_valid", 32'(ov_rr), 32'(m_ov[0]));
        chk("rr_out_sel",   32'(os_rr), 32'(m_sel[0]));
        chk("rr_out_data",  od_rr,      m_data[0]);
        chk("fp_out_valid", 32'(ov_fp), 32'(m_ov[1]));
        chk("fp_out_sel",   32'(os_fp), 32'(m_sel[1]));
        chk("fp_out_data",  od_fp,      m_data[1]);
        chk("rr3_out_valid", 32'(ov3),  32'(m_ov[2]));
        chk("rr3_out_sel",   32'(os3),  32'(m_sel[2]));
        chk("rr3_out_data",  32'(od3),  m_data[2]);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] en;
        logic       ordy;
        logic [3:0] rdy_rr;
        logic [3:0] rdy_fp;
        logic       ov;
        logic [1:0] sel_rr;
        logic [1:0] sel_fp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [127:0] dA;
        logic [127:0] dB;
        logic [127:0] rnd;
        dA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        dB = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};

        // rst, valid, enable, out_ready | in_ready rr, fp | out_valid, sel rr, sel fp
        tbl.push_back('{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 4'h1, 1'b1, 2'd1, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 4'h1, 1'b1, 2'd2, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 4'h1, 1'b1, 2'd3, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hD, 1'b1, 4'h4, 4'h1, 1'b1, 2'd2, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hD, 1'b1, 4'h8, 4'h1, 1'b1, 2'd3, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hD, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hD, 1'b1, 4'h4, 4'h1, 1'b1, 2'd2, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 2'd0});
        tbl.push_back('{1'b0, 4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd2, 2'd0});
        tbl.push_back('{1'b0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 2'd2, 2'd0});
        tbl.push_back('{1'b0, 4'h4, 4'hF, 1'b0, 4'h4, 4'h4, 1'b1, 2'd2, 2'd2});
        tbl.push_back('{1'b0, 4'h1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 2'd2});
        tbl.push_back('{1'b0, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 2'd0});
        tbl.push_back('{1'b0, 4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0});

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].en, tbl[i].ordy, dA);
            chk($sformatf("tbl%0d_rr_ready", i), 32'(s_rdy_rr), 32'(tbl[i].rdy_rr));
            chk($sformatf("tbl%0d_fp_ready", i), 32'(s_rdy_fp), 32'(tbl[i].rdy_fp));
            chk($sformatf("tbl%0d_ov", i), 32'({ov_rr, ov_fp}), 32'({tbl[i].ov, tbl[i].ov}));
            chk($sformatf("tbl%0d_rr_sel", i), 32'(os_rr), 32'(tbl[i].sel_rr));
            chk($sformatf("tbl%0d_fp_sel", i), 32'(os_fp), 32'(tbl[i].sel_fp));
            chk($sformatf("tbl%0d_rr_data", i), od_rr, tbl[i].rst ? 32'd0 : 32'hA0 + 32'(tbl[i].sel_rr));
        end

        // Backpressure holds a word, then drain and refill together.
        cycle(1'b1, 4'h0, 4'hF, 1'b1, dB);
        cycle(1'b0, 4'h4, 4'hF, 1'b1, dB);
        chk("bp_load_ready", 32'(s_rdy_rr), 32'h4);
        chk("bp_load_data", od_rr, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'h2, 4'hF, 1'b0, dB);
            chk("bp_hold_ready", 32'(s_rdy_rr), 32'h0);
            chk("bp_hold_data", od_rr, 32'hDEADBEEF);
            chk("bp_hold_valid", 32'(ov_rr), 32'd1);
        end
        cycle(1'b0, 4'h2, 4'hF, 1'b1, dB);
        chk("bp_release_ready", 32'(s_rdy_rr), 32'h2);
        chk("bp_release_data", od_rr, 32'h11111111);
        chk("bp_release_sel", 32'(os_rr), 32'd1);

        // Pointer wraps after granting the last channel.
        cycle(1'b1, 4'h0, 4'hF, 1'b1, dA);
        cycle(1'b0, 4'h8, 4'hF, 1'b1, dA);
        chk("wrap_ch3_sel", 32'(os_rr), 32'd3);
        cycle(1'b0, 4'h9, 4'hF, 1'b1, dA);
        chk("wrap_ch0_ready", 32'(s_rdy_rr), 32'h1);
        chk("wrap_ch0_sel", 32'(os_rr), 32'd0);

        // Reset mid-stream discards the word and restarts the scan at channel 0.
        cycle(1'b0, 4'hF, 4'hF, 1'b1, dA);
        cycle(1'b0, 4'hF, 4'hF, 1'b1, dA);
        chk("rst_pre_sel", 32'(os_rr), 32'd2);
        cycle(1'b1, 4'hF, 4'hF, 1'b1, dA);
        chk("rst_ready_forced", 32'(s_rdy_rr), 32'h0);
        chk("rst_out_valid", 32'(ov_rr), 32'd0);
        chk("rst_out_data", od_rr, 32'd0);
        chk("rst_out_sel", 32'(os_rr), 32'd0);
        cycle(1'b0, 4'hF, 4'hF, 1'b1, dA);
        chk("rst_first_grant", 32'(s_rdy_rr), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            cycle(($urandom_range(0, 49) == 0),
                  4'($urandom),
                  ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom),
                  ($urandom_range(0, 3) != 0),
                  rnd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_arb_mux.md
STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: width of each data channel in bits.
REQ-002 Parameter NUM_IN, default 4: number of input channels; legal range 2..16.
REQ-003 Parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004 Localparam SELW = $clog2(NUM_IN): width of the channel index.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  NUM_IN  per-channel request; bit i qualifies channel i.
REQ-008 in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  NUM_IN  per-channel accept; combinational, at most one bit set per cycle.
REQ-010 ch_enable  input  NUM_IN  per-channel mask; a cleared bit excludes that channel from arbitration.
REQ-011 out_valid  output  1  the output register holds a word.
REQ-012 out_data  output  WIDTH  registered output word.
REQ-013 out_sel  output  SELW  registered index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Eligible set: req[i] = in_valid[i] & ch_enable[i].
REQ-016 Load enable: load = ~out_valid | out_ready; the output register refills in the same cycle it drains.
REQ-017 A transfer on channel i occurs when load & grant[i]; in_ready[i] = load & grant[i]; in_ready = 0 when load = 0 or req = 0.
REQ-018 In fixed mode, grant selects the lowest-index set bit of req.
REQ-019 In round-robin mode, grant selects the first set bit of req scanning ptr, ptr+1, ... NUM_IN-1, 0, ... ptr-1, with modulo-NUM_IN wrap.
REQ-020 ptr (SELW bits) updates to (granted index + 1) mod NUM_IN only on a completed input transfer and holds otherwise; ptr is not used in fixed mode.
REQ-021 On an input transfer: out_data <= granted channel data, out_sel <= granted index, out_valid <= 1 at the next edge; latency is 1 cycle from input handshake to out_valid.
REQ-022 When out_ready = 1 and there is no input transfer, out_valid <= 0; out_data and out_sel hold.
REQ-023 When out_valid = 1 and out_ready = 0, out_valid, out_data and out_sel hold, and all in_ready bits are 0 (backpressure).
REQ-024 Drain and refill in the same cycle produce back-to-back output words with no bubble; sustained throughput is 1 word per cycle.
REQ-025 The arbiter has no combinational path from in_data to out_data; in_ready depends combinationally on in_valid, ch_enable, out_valid and out_ready only.
REQ-026 A channel that drops in_valid before being granted loses its turn with no side effect; ptr does not move.
REQ-027 Changes to ch_enable take effect in the same cycle and do not alter ptr.
REQ-028 When NUM_IN is not a power of two, ptr never holds a value of NUM_IN or above.

Reset
REQ-029 While reset = 1 at a rising edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-030 During reset, in_ready is forced to 0 regardless of the other inputs.
REQ-031 Reset asserted mid-operation discards the word held in the output register, and the first grant after reset starts scanning from channel 0.

Verification
REQ-032 Setup NUM_IN=4, WIDTH=32, RR_MODE=1, out_ready=1, all channels valid with data 0xA0..0xA3 held -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-033 Same stimulus with RR_MODE=0 -> out_sel = 0 every cycle, and in_ready[3:1] never asserts.
REQ-034 A word from ch2 (0xDEADBEEF) is loaded, then out_ready=0 for 3 cycles while ch1 is valid -> out_data holds 0xDEADBEEF with out_valid=1 and in_ready=0 throughout; on out_ready=1, ch1 is accepted in that cycle and appears on the next cycle.
REQ-035 Only ch3 valid while ptr=0 -> ch3 is granted and ptr becomes 0 (wrap); a subsequent request on ch0 and ch3 together grants ch0.
REQ-036 ch_enable=4'b1101 with all channels valid -> channel 1 is never granted, and the round-robin order is 0,2,3,0.
REQ-037 reset asserted for one cycle while out_valid=1 and ptr=2 -> next cycle out_valid=0, out_data=0, out_sel=0; the first grant afterwards, with all channels valid, is channel 0.
